// File: rtl/muldiv_sequencer_if.sv
// Operand/result bundle for the sequential signed multiply/divide unit.
// The requester drives start/op/a/b and the unit returns busy/done/hi/lo/dbz.
interface muldiv_sequencer_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic             op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             dbz;

   modport master (output start, op, a, b, input busy, done, hi, lo, dbz);
   modport slave  (input start, op, a, b, output busy, done, hi, lo, dbz);
endinterface

// File: rtl/muldiv_sequencer.sv
// Sequential signed multiply (radix-4 Booth, WIDTH/2+1 cycles) and divide (non-restoring, WIDTH+2 cycles).
// One operation in flight; start is only sampled in IDLE, and results hold until the next done or clear.
module muldiv_sequencer #(
   parameter int WIDTH = 32
) (
   input logic               clock,
   input logic               clear,
   muldiv_sequencer_if.slave bus
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] MUL_LAST = CW'(WIDTH / 2 - 1);
   localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH - 1);

   typedef enum logic [2:0] {IDLE, MUL_RUN, DIV_RUN, DIV_FIX, DONE} state_t;

   state_t               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   mcand_q, mcand_d;
   logic [WIDTH:0]       mplr_q, mplr_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [WIDTH+1:0]     rem_q, rem_d;
   logic [WIDTH-1:0]     quo_q, quo_d;
   logic [WIDTH-1:0]     dvsr_q, dvsr_d;
   logic                 negq_q, negq_d;
   logic                 negr_q, negr_d;
   logic [WIDTH-1:0]     hi_q, hi_d;
   logic [WIDTH-1:0]     lo_q, lo_d;
   logic                 dbz_q, dbz_d;

   logic                 b_zero;
   logic [WIDTH-1:0]     a_mag, b_mag;
   logic [2*WIDTH-1:0]   booth_term, acc_sum;
   logic [WIDTH+1:0]     rem_sh, rem_step, dvsr_ext;
   logic [WIDTH-1:0]     quo_step, rem_mag, rem_fix, quo_fix;

   // Booth digit from multiplier bits {2i+1, 2i, 2i-1}; mcand_q is pre-shifted by 2i.
   always_comb begin
      booth_term = '0;
      case (mplr_q[2:0])
         3'b001, 3'b010: booth_term = mcand_q;
         3'b011:         booth_term = mcand_q << 1;
         3'b100:         booth_term = -(mcand_q << 1);
         3'b101, 3'b110: booth_term = -mcand_q;
         default:        booth_term = '0;
      endcase
      acc_sum = acc_q + booth_term;
   end

   always_comb begin
      b_zero   = (bus.b == '0);
      a_mag    = bus.a[WIDTH-1] ? -bus.a : bus.a;
      b_mag    = bus.b[WIDTH-1] ? -bus.b : bus.b;
      dvsr_ext = {2'b00, dvsr_q};
      rem_sh   = {rem_q[WIDTH:0], quo_q[WIDTH-1]};
      rem_step = rem_q[WIDTH+1] ? rem_sh + dvsr_ext : rem_sh - dvsr_ext;
      quo_step = {quo_q[WIDTH-2:0], ~rem_step[WIDTH+1]};
      // Final remainder lies in [0, divisor), so modulo-2^WIDTH correction is exact.
      rem_mag  = rem_q[WIDTH-1:0] + (rem_q[WIDTH+1] ? dvsr_q : '0);
      rem_fix  = negr_q ? -rem_mag : rem_mag;
      quo_fix  = negq_q ? -quo_q : quo_q;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.start) state_d = !bus.op ? MUL_RUN : (b_zero ? DONE : DIV_RUN);
         MUL_RUN: if (cnt_q == MUL_LAST) state_d = DONE;
         DIV_RUN: if (cnt_q == DIV_LAST) state_d = DIV_FIX;
         DIV_FIX: state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      cnt_d   = cnt_q;
      mcand_d = mcand_q;
      mplr_d  = mplr_q;
      acc_d   = acc_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      dvsr_d  = dvsr_q;
      negq_d  = negq_q;
      negr_d  = negr_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      dbz_d   = dbz_q;
      case (state_q)
         IDLE: if (bus.start) begin
            cnt_d   = '0;
            mcand_d = {{WIDTH{bus.a[WIDTH-1]}}, bus.a};
            mplr_d  = {bus.b, 1'b0};
            acc_d   = '0;
            rem_d   = '0;
            quo_d   = a_mag;
            dvsr_d  = b_mag;
            negq_d  = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
            negr_d  = bus.a[WIDTH-1];
            if (bus.op && b_zero) begin
               hi_d  = bus.a;
               lo_d  = '1;
               dbz_d = 1'b1;
            end
         end
         MUL_RUN: begin
            acc_d   = acc_sum;
            mcand_d = mcand_q << 2;
            mplr_d  = {mplr_q[WIDTH], mplr_q[WIDTH], mplr_q[WIDTH:2]};
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == MUL_LAST) begin
               cnt_d = '0;
               hi_d  = acc_sum[2*WIDTH-1:WIDTH];
               lo_d  = acc_sum[WIDTH-1:0];
               dbz_d = 1'b0;
            end
         end
         DIV_RUN: begin
            rem_d = rem_step;
            quo_d = quo_step;
            cnt_d = (cnt_q == DIV_LAST) ? '0 : cnt_q + CW'(1);
         end
         DIV_FIX: begin
            hi_d  = rem_fix;
            lo_d  = quo_fix;
            dbz_d = 1'b0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock) begin
      if (clear) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         mcand_q <= '0;
         mplr_q  <= '0;
         acc_q   <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         dvsr_q  <= '0;
         negq_q  <= 1'b0;
         negr_q  <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mcand_q <= mcand_d;
         mplr_q  <= mplr_d;
         acc_q   <= acc_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         dvsr_q  <= dvsr_d;
         negq_q  <= negq_d;
         negr_q  <= negr_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         dbz_q   <= dbz_d;
      end
   end

   always_comb begin
      bus.busy = (state_q == MUL_RUN) || (state_q == DIV_RUN) || (state_q == DIV_FIX);
      bus.done = (state_q == DONE);
      bus.hi   = hi_q;
      bus.lo   = lo_q;
      bus.dbz  = dbz_q;
   end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized and directed bench for muldiv_sequencer against a plain signed-arithmetic reference model.
module tb_muldiv_sequencer;
   localparam int W = 32;

   logic clock = 1'b0;
   logic clear;
   int   cmp_cnt = 0;
   int   err_cnt = 0;

   muldiv_sequencer_if #(.WIDTH(W)) bus ();
   muldiv_sequencer #(.WIDTH(W)) dut (.clock(clock), .clear(clear), .bus(bus));

   always #5 clock = ~clock;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference: exact signed arithmetic on 64-bit integers.
   function automatic void model(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] hi, output logic [W-1:0] lo,
                                 output logic dbz, output int lat);
      longint sa, sb, p, q, r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (!op) begin
         p = sa * sb;
         hi = p[2*W-1:W]; lo = p[W-1:0]; dbz = 1'b0; lat = W / 2 + 1;
      end else if (sb == 0) begin
         hi = a; lo = '1; dbz = 1'b1; lat = 1;
      end else begin
         q = sa / sb;
         r = sa % sb;
         hi = r[W-1:0]; lo = q[W-1:0]; dbz = 1'b0; lat = W + 2;
      end
   endfunction

   function automatic logic [W-1:0] pick_val();
      logic [W-1:0] edge_vals [8] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000,
                                      32'h7FFFFFFF, 32'h2, 32'hFFFFFFFE, 32'h80000001};
      if ($urandom_range(0, 3) == 0) return edge_vals[$urandom_range(0, 7)];
      if ($urandom_range(0, 3) == 0) return W'($signed($urandom_range(0, 40)) - 20);
      return W'($urandom);
   endfunction

   // Issue one operation from just after a rising edge; returns results seen in the done cycle.
   task automatic do_op(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] hi, output logic [W-1:0] lo, output logic dbz,
                        output int lat, output bit busy_ok);
      bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
      @(posedge clock); #1;
      bus.start = 1'b0; bus.op = 1'($urandom); bus.a = W'($urandom); bus.b = W'($urandom);
      lat = 0; busy_ok = 1'b1; hi = bus.hi; lo = bus.lo; dbz = bus.dbz;
      while (1) begin
         lat++;
         @(negedge clock);
         if (bus.done === 1'b1) begin
            hi = bus.hi; lo = bus.lo; dbz = bus.dbz;
            if (bus.busy !== 1'b0) busy_ok = 1'b0;
            break;
         end
         if (bus.busy !== 1'b1) busy_ok = 1'b0;
         if (lat >= 100) break;
         @(posedge clock); #1;
      end
      @(posedge clock); #1;
   endtask

   task automatic test_reset();
      logic [W-1:0] hi, lo, ehi, elo;
      logic dbz, edbz;
      int lat, elat;
      bit bok;
      clear = 1'b1; bus.start = 1'b1; bus.op = 1'b0; bus.a = 32'd3; bus.b = 32'd5;
      repeat (3) @(posedge clock);
      @(negedge clock);
      cmp_cnt++;
      if ({bus.busy, bus.done, bus.dbz, bus.hi, bus.lo} !== '0) begin
         err_cnt++;
         $display("FAIL reset_outputs: busy=%b done=%b dbz=%b hi=%h lo=%h, want all zero",
                  bus.busy, bus.done, bus.dbz, bus.hi, bus.lo);
      end
      @(posedge clock); #1;
      clear = 1'b0;
      model(1'b0, 32'd3, 32'd5, ehi, elo, edbz, elat);
      do_op(1'b0, 32'd3, 32'd5, hi, lo, dbz, lat, bok);
      cmp_cnt++;
      if ({hi, lo, dbz, lat} !== {ehi, elo, edbz, elat}) begin
         err_cnt++;
         $display("FAIL start_after_reset: hi=%h lo=%h lat=%0d, want hi=%h lo=%h lat=%0d",
                  hi, lo, lat, ehi, elo, elat);
      end
   endtask

   task automatic test_directed(input string name, input logic op, input logic [W-1:0] a,
                                input logic [W-1:0] b);
      logic [W-1:0] hi, lo, ehi, elo;
      logic dbz, edbz;
      int lat, elat;
      bit bok;
      model(op, a, b, ehi, elo, edbz, elat);
      do_op(op, a, b, hi, lo, dbz, lat, bok);
      cmp_cnt++;
      if (hi !== ehi || lo !== elo) begin
         err_cnt++;
         $display("FAIL %s_result: hi=%h lo=%h, want hi=%h lo=%h", name, hi, lo, ehi, elo);
      end
      cmp_cnt++;
      if (dbz !== edbz) begin
         err_cnt++;
         $display("FAIL %s_dbz: got %b want %b", name, dbz, edbz);
      end
      cmp_cnt++;
      if (lat !== elat) begin
         err_cnt++;
         $display("FAIL %s_latency: got %0d want %0d", name, lat, elat);
      end
      cmp_cnt++;
      if (bok !== 1'b1) begin
         err_cnt++;
         $display("FAIL %s_busy: busy profile wrong, got ok=%b want 1", name, bok);
      end
   endtask

   task automatic test_mul();
      test_directed("mul_6_m7", 1'b0, 32'd6, 32'hFFFFFFF9);
      test_directed("mul_min_min", 1'b0, 32'h80000000, 32'h80000000);
      test_directed("mul_m1_m1", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
      test_directed("mul_max_min", 1'b0, 32'h7FFFFFFF, 32'h80000000);
   endtask

   task automatic test_div();
      test_directed("div_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2);
      test_directed("div_min_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF);
      test_directed("div_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE);
      test_directed("div_m7_m2", 1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE);
      test_directed("div_min_min", 1'b1, 32'h80000000, 32'h80000000);
      test_directed("div_max_1", 1'b1, 32'h7FFFFFFF, 32'd1);
   endtask

   task automatic test_dbz();
      test_directed("div_5_0", 1'b1, 32'd5, 32'd0);
      test_directed("mul_after_dbz", 1'b0, 32'd3, 32'd4);
   endtask

   task automatic test_clear_abort();
      bit saw_done = 1'b0;
      bus.start = 1'b1; bus.op = 1'b0; bus.a = 32'd1234; bus.b = 32'd99;
      @(posedge clock); #1;
      bus.start = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         if (c == 8) clear = 1'b1;
         @(negedge clock);
         if (bus.done === 1'b1) saw_done = 1'b1;
         @(posedge clock); #1;
      end
      clear = 1'b0;
      @(negedge clock);
      cmp_cnt++;
      if ({bus.busy, bus.done, bus.dbz, bus.hi, bus.lo} !== '0) begin
         err_cnt++;
         $display("FAIL abort_outputs: busy=%b done=%b dbz=%b hi=%h lo=%h, want all zero",
                  bus.busy, bus.done, bus.dbz, bus.hi, bus.lo);
      end
      for (int c = 0; c < 20; c++) begin
         @(negedge clock);
         if (bus.done === 1'b1 || bus.busy === 1'b1) saw_done = 1'b1;
      end
      cmp_cnt++;
      if (saw_done !== 1'b0) begin
         err_cnt++;
         $display("FAIL abort_no_done: activity seen=%b want 0", saw_done);
      end
      @(posedge clock); #1;
   endtask

   task automatic test_start_held();
      logic [W-1:0] ehi, elo, hi, lo;
      logic edbz;
      int elat, ndone = 0, dcyc = -1;
      model(1'b0, 32'hFFFFCFC7, 32'd678, ehi, elo, edbz, elat);
      bus.start = 1'b1; bus.op = 1'b0; bus.a = 32'hFFFFCFC7; bus.b = 32'd678;
      hi = '0; lo = '0;
      @(posedge clock); #1;
      for (int c = 1; c <= 25; c++) begin
         if (c == 17) bus.start = 1'b0;
         else if (c < 17) begin bus.a = W'($urandom); bus.b = W'($urandom); bus.op = 1'($urandom); end
         @(negedge clock);
         if (bus.done === 1'b1) begin ndone++; dcyc = c; hi = bus.hi; lo = bus.lo; end
         @(posedge clock); #1;
      end
      cmp_cnt++;
      if (ndone !== 1 || dcyc !== elat) begin
         err_cnt++;
         $display("FAIL held_start_done: pulses=%0d cycle=%0d, want 1 pulse in cycle %0d", ndone, dcyc, elat);
      end
      cmp_cnt++;
      if (hi !== ehi || lo !== elo) begin
         err_cnt++;
         $display("FAIL held_start_latch: hi=%h lo=%h, want hi=%h lo=%h", hi, lo, ehi, elo);
      end
   endtask

   task automatic test_random(input int n);
      logic [W-1:0] a, b, hi, lo, ehi, elo, phi, plo;
      logic op, dbz, edbz, pdbz;
      int lat, elat;
      bit bok;
      phi = bus.hi; plo = bus.lo; pdbz = bus.dbz;
      for (int i = 0; i < n; i++) begin
         repeat ($urandom_range(0, 2)) begin @(posedge clock); #1; end
         cmp_cnt++;
         if ({bus.hi, bus.lo, bus.dbz} !== {phi, plo, pdbz}) begin
            err_cnt++;
            $display("FAIL rand_hold[%0d]: hi=%h lo=%h dbz=%b, want hi=%h lo=%h dbz=%b",
                     i, bus.hi, bus.lo, bus.dbz, phi, plo, pdbz);
         end
         op = 1'($urandom);
         a = pick_val();
         b = pick_val();
         model(op, a, b, ehi, elo, edbz, elat);
         do_op(op, a, b, hi, lo, dbz, lat, bok);
         cmp_cnt++;
         if ({hi, lo, dbz, lat, bok} !== {ehi, elo, edbz, elat, 1'b1}) begin
            err_cnt++;
            $display("FAIL rand_op[%0d] op=%b a=%h b=%h: hi=%h lo=%h dbz=%b lat=%0d busy_ok=%b, want hi=%h lo=%h dbz=%b lat=%0d",
                     i, op, a, b, hi, lo, dbz, lat, bok, ehi, elo, edbz, elat);
         end
         phi = ehi; plo = elo; pdbz = edbz;
      end
   endtask

   initial begin
      clear = 1'b1;
      bus.start = 1'b0; bus.op = 1'b0; bus.a = '0; bus.b = '0;
      @(posedge clock); #1;
      test_reset();
      test_mul();
      test_div();
      test_dbz();
      test_clear_abort();
      test_start_held();
      test_random(1500);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end
endmodule
